formula_witness_search: RTL and testbench
=========================================

// Module: formula_witness_search
// PURPOSE
//  Inverse of the 7-input c17 benchmark formula evaluator. Given a target output
//  value and fixed values for the universal inputs, it searches the existential
//  inputs (selected by Y_MASK) for an assignment that drives the formula to the
//  target. Serves as the sequential witness/Skolem-check engine next to the
//  combinational formula blocks.
// PARAMETERS
//  Y_MASK   7'b1100000  bit k=1 -> input ik is existential (searched); 0 -> universal
// PORTS
//  clk         in   1  clock, rising edge
//  rst_n       in   1  asynchronous active-low reset
//  start       in   1  request pulse; sampled only in IDLE
//  target_out  in   1  required formula output value
//  x_in        in   7  universal input values (bit k = ik); bits under Y_MASK ignored
//  busy        out  1  high in SEARCH
//  done        out  1  one-cycle pulse, search finished
//  found       out  1  valid with done, held until next start: witness exists
//  witness     out  7  full 7-bit assignment (bit k = ik), held until next start
//  sol_count   out  8  only with FWS_SOL_COUNT_EN: number of satisfying candidates
// BEHAVIOUR
//  Formula f(a), with a[k]=ik:
//   N10=~(a0&a2); N11=~(a2&a3); N16=~(a1&N11);
//   P=~(N10&N16); Q=~(N10&a5); f=~(P^Q).
//  Reset: state=IDLE; busy, done, found, witness, cnt, x_reg, tgt_reg, sol_count = 0.
//  FSM IDLE -> SEARCH -> DONE -> IDLE:
//   IDLE: start=1 -> capture x_reg = x_in & ~Y_MASK, tgt_reg = target_out;
//         cnt=0; clear found, witness, sol_count; go to SEARCH.
//   SEARCH: each cycle evaluates exactly one candidate c = x_reg | cnt (cnt
//         holds only Y_MASK bits). Next subset: nxt = ((cnt | ~Y_MASK) + 1) & Y_MASK
//         (7-bit, carry out dropped). Candidates run in ascending subset order,
//         starting with cnt=0.
//         If f(c)==tgt_reg on the first match: witness <= c, found <= 1, go to DONE.
//         If nxt==0 (space exhausted, no match): found=0, witness=0, go to DONE.
//   DONE: done=1 for exactly one cycle; go to IDLE.
//  Latency: start sampled at edge k; candidate n (0-based) evaluated in cycle
//   k+1+n; done high in cycle k+2+n where n is the match or the last candidate.
//   Worst case 2^popcount(Y_MASK) candidates.
//  Y_MASK=0: exactly one candidate (x_reg). Y_MASK=7'h7F: 128 candidates, x_in ignored.
//  start while busy or in DONE: ignored, not queued.
//  x_in and target_out changes after capture: no effect on the running search.
//  rst_n low mid-search: immediate return to IDLE with all outputs at reset values.
// CONFIGURATION
//  FWS_SOL_COUNT_EN defined: search never stops early. Every candidate is
//   evaluated; sol_count increments on each match and saturates at 8'd255.
//   witness/found still report the first match. done follows the last candidate.
//  Not defined: early stop on first match; sol_count port absent.
// TESTING
//  Default mask. x_in=0, target=1 -> cand 0x00 fails, 0x20 matches; done at k+3;
//   found=1, witness=7'h20.
//  x_in=7'h05 (i0=i2=1), target=0 -> f constant 1; 4 candidates; done at k+5;
//   found=0, witness=0.
//  x_in=7'h05, target=1 -> found at cand 0; done at k+2; witness=7'h05.
//  x_in=7'h02, target=1 -> f=~i5; witness=7'h02. Then assert rst_n=0 one cycle into
//   the next search -> all outputs 0, IDLE.
//  FWS_SOL_COUNT_EN: x_in=0, target=1 -> sol_count=2, witness=7'h20, done at k+5;
//   x_in=7'h05, target=1 -> sol_count=4.
//  Y_MASK=7'h7F, random target: compare found/witness against a software
//   exhaustive model over all 128 inputs; start pulses during busy are ignored.

Source files
------------

// File: rtl/formula_witness_search.sv
// formula_witness_search
//   Sequential witness search for the 7-input c17 formula. A target output
//   value and the universal inputs are captured on start; the existential
//   inputs (bits set in Y_MASK) are then enumerated in ascending subset order,
//   one candidate per clock, until an assignment that drives the formula to
//   the target is found or the subset space is exhausted.
//   Optional feature macro: FWS_SOL_COUNT_EN -- disables the early stop and
//   counts every satisfying candidate on the sol_count port (saturating).
//   state_dbg exposes the FSM state (0=IDLE, 1=SEARCH, 2=DONE) for checkers.
//   Handshake: start is a request pulse sampled only in IDLE; done is a
//   one-cycle completion pulse, and found/witness stay valid from done until
//   the next accepted start.
module formula_witness_search #(
    parameter logic [6:0] Y_MASK = 7'b1100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       target_out,
    input  logic [6:0] x_in,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [6:0] witness,
`ifdef FWS_SOL_COUNT_EN
    output logic [7:0] sol_count,
`endif
    output logic [1:0] state_dbg
);

    // Universal-input positions: the complement of the searched positions.
    localparam logic [6:0] U_MASK = ~Y_MASK;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       found_q, found_d;
    logic [6:0] witness_q, witness_d;
    logic [6:0] cnt_q, cnt_d;
    logic [6:0] x_reg_q, x_reg_d;
    logic       tgt_reg_q, tgt_reg_d;
`ifdef FWS_SOL_COUNT_EN
    logic [7:0] sol_count_q, sol_count_d;
`endif

    logic [6:0] cand;
    logic [6:0] nxt;
    logic       match;

    // c17 formula: N10=~(a0&a2), N11=~(a2&a3), N16=~(a1&N11),
    // P=~(N10&N16), Q=~(N10&a5), f=~(P^Q).
    function automatic logic f_eval(input logic [6:0] a);
        logic n10;
        logic n11;
        logic n16;
        logic p;
        logic q;
        n10 = ~(a[0] & a[2]);
        n11 = ~(a[2] & a[3]);
        n16 = ~(a[1] & n11);
        p   = ~(n10 & n16);
        q   = ~(n10 & a[5]);
        return ~(p ^ q);
    endfunction

    // Candidate evaluation and next-subset step. Forcing the universal bits to
    // one before the increment makes the carry ripple straight through them,
    // so the masked result is the next subset of Y_MASK in ascending order;
    // it wraps to zero once the space is exhausted.
    always_comb begin
        cand  = x_reg_q | cnt_q;
        nxt   = ((cnt_q | U_MASK) + 7'd1) & Y_MASK;
        match = (f_eval(cand) == tgt_reg_q);
    end

    // Next-state and next-output logic for the IDLE -> SEARCH -> DONE sequence.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        found_d     = found_q;
        witness_d   = witness_q;
        cnt_d       = cnt_q;
        x_reg_d     = x_reg_q;
        tgt_reg_d   = tgt_reg_q;
`ifdef FWS_SOL_COUNT_EN
        sol_count_d = sol_count_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    x_reg_d     = x_in & U_MASK;
                    tgt_reg_d   = target_out;
                    cnt_d       = 7'd0;
                    found_d     = 1'b0;
                    witness_d   = 7'd0;
`ifdef FWS_SOL_COUNT_EN
                    sol_count_d = 8'd0;
`endif
                    busy_d      = 1'b1;
                    state_d     = S_SEARCH;
                end
            end
            S_SEARCH: begin
`ifdef FWS_SOL_COUNT_EN
                // Full sweep: count every match, report only the first one.
                if (match) begin
                    if (sol_count_q != 8'd255) begin
                        sol_count_d = sol_count_q + 8'd1;
                    end
                    if (!found_q) begin
                        found_d   = 1'b1;
                        witness_d = cand;
                    end
                end
                if (nxt == 7'd0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    cnt_d = nxt;
                end
`else
                // Early stop on the first satisfying candidate.
                if (match) begin
                    found_d   = 1'b1;
                    witness_d = cand;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else if (nxt == 7'd0) begin
                    found_d   = 1'b0;
                    witness_d = 7'd0;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = nxt;
                end
`endif
            end
            S_DONE: begin
                // done drops here; start is not sampled until IDLE.
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; asynchronous reset clears everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            witness_q   <= 7'd0;
            cnt_q       <= 7'd0;
            x_reg_q     <= 7'd0;
            tgt_reg_q   <= 1'b0;
`ifdef FWS_SOL_COUNT_EN
            sol_count_q <= 8'd0;
`endif
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            found_q     <= found_d;
            witness_q   <= witness_d;
            cnt_q       <= cnt_d;
            x_reg_q     <= x_reg_d;
            tgt_reg_q   <= tgt_reg_d;
`ifdef FWS_SOL_COUNT_EN
            sol_count_q <= sol_count_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign found     = found_q;
    assign witness   = witness_q;
    assign state_dbg = state_q;
`ifdef FWS_SOL_COUNT_EN
    assign sol_count = sol_count_q;
`endif

endmodule

// File: tb/tb_formula_witness_search.sv
// tb_formula_witness_search
//   Bench for formula_witness_search: one instance with the default mask and
//   one with every input existential. Results are compared with an exhaustive
//   software search over the candidate space. Build with FWS_SOL_COUNT_EN to
//   exercise the solution-counting variant.
module tb_formula_witness_search;

    localparam logic [6:0] MASK_D = 7'b1100000;
    localparam logic [6:0] MASK_A = 7'h7F;
    localparam int MAX_EDGES = 300;

    logic       clk;
    logic       rst_n;
    logic       start_v   [2];
    logic       tgt_v     [2];
    logic [6:0] x_v       [2];
    logic       busy_w    [2];
    logic       done_w    [2];
    logic       found_w   [2];
    logic [6:0] witness_w [2];
    logic [1:0] state_w   [2];
`ifdef FWS_SOL_COUNT_EN
    logic [7:0] sol_w     [2];
`endif

    int n_vec;
    int n_mis;

    formula_witness_search #(.Y_MASK(MASK_D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[0]),
        .target_out (tgt_v[0]),
        .x_in       (x_v[0]),
        .busy       (busy_w[0]),
        .done       (done_w[0]),
        .found      (found_w[0]),
        .witness    (witness_w[0]),
`ifdef FWS_SOL_COUNT_EN
        .sol_count  (sol_w[0]),
`endif
        .state_dbg  (state_w[0])
    );

    formula_witness_search #(.Y_MASK(MASK_A)) dut_all (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start_v[1]),
        .target_out (tgt_v[1]),
        .x_in       (x_v[1]),
        .busy       (busy_w[1]),
        .done       (done_w[1]),
        .found      (found_w[1]),
        .witness    (witness_w[1]),
`ifdef FWS_SOL_COUNT_EN
        .sol_count  (sol_w[1]),
`endif
        .state_dbg  (state_w[1])
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // The formula straight from its gate equations, on plain bits.
    function automatic bit formula(input logic [6:0] a);
        bit n10, n11, n16, p, q;
        n10 = !(a[0] && a[2]);
        n11 = !(a[2] && a[3]);
        n16 = !(a[1] && n11);
        p   = !(n10 && n16);
        q   = !(n10 && a[5]);
        return p == q;
    endfunction

    // Exhaustive reference: walk every value 0..127, keep those that live
    // entirely inside the mask (that is ascending subset order), evaluate the
    // candidate and record first match, candidate count and match count.
    task automatic model(input int sel, input logic [6:0] x, input bit tgt,
                         output bit e_found, output logic [6:0] e_wit,
                         output int e_lat, output int e_cnt);
        logic [6:0] mask;
        logic [6:0] c;
        int first;
        int idx;
        mask    = (sel == 0) ? MASK_D : MASK_A;
        first   = -1;
        idx     = 0;
        e_cnt   = 0;
        e_wit   = 7'd0;
        for (int v = 0; v < 128; v++) begin
            if ((7'(v) & ~mask) == 7'd0) begin
                c = (x & ~mask) | 7'(v);
                if (formula(c) == tgt) begin
                    e_cnt++;
                    if (first < 0) begin
                        first = idx;
                        e_wit = c;
                    end
                end
                idx++;
            end
        end
        if (e_cnt > 255) e_cnt = 255;
        e_found = (first >= 0);
`ifdef FWS_SOL_COUNT_EN
        e_lat = idx;
`else
        e_lat = e_found ? first + 1 : idx;
`endif
    endtask

    // Driver: launch one search on instance sel and check it against the model.
    // With inject set, start is held high and x/target are scrambled while the
    // search runs; none of that may disturb the result.
    task automatic run_search(input int sel, input logic [6:0] x, input bit tgt, input bit inject,
                              output bit o_found, output logic [6:0] o_wit, output int o_lat);
        bit         e_found;
        logic [6:0] e_wit;
        int         e_lat;
        int         e_cnt;
        bit         seen;
        model(sel, x, tgt, e_found, e_wit, e_lat, e_cnt);
        @(negedge clk);
        start_v[sel] = 1'b1;
        x_v[sel]     = x;
        tgt_v[sel]   = tgt;
        @(posedge clk);
        #1;
        if (!inject) start_v[sel] = 1'b0;
        check_eq("busy_after_start", busy_w[sel], 1'b1);
        seen  = 1'b0;
        o_lat = 0;
        for (int e = 1; e <= MAX_EDGES; e++) begin
            @(posedge clk);
            #1;
            if (inject) begin
                x_v[sel]   = 7'($urandom_range(0, 127));
                tgt_v[sel] = 1'($urandom_range(0, 1));
            end
            if (done_w[sel]) begin
                seen  = 1'b1;
                o_lat = e;
                break;
            end
        end
        start_v[sel] = 1'b0;
        check_eq("done_seen", seen, 1'b1);
        o_found = found_w[sel];
        o_wit   = witness_w[sel];
        check_eq("latency", o_lat, e_lat);
        check_eq("found", o_found, e_found);
        check_eq("witness", o_wit, e_wit);
        check_eq("busy_at_done", busy_w[sel], 1'b0);
`ifdef FWS_SOL_COUNT_EN
        check_eq("sol_count", sol_w[sel], e_cnt);
`endif
        @(posedge clk);
        #1;
        check_eq("done_one_cycle", done_w[sel], 1'b0);
        check_eq("idle_after_done", busy_w[sel], 1'b0);
        check_eq("found_held", found_w[sel], e_found);
        check_eq("witness_held", witness_w[sel], e_wit);
    endtask

    // Main sequence: reset checks, directed cases, mid-search reset, random sweeps.
    initial begin
        bit         f;
        logic [6:0] w;
        int         lat;
        n_vec = 0;
        n_mis = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            start_v[i] = 1'b0;
            tgt_v[i]   = 1'b0;
            x_v[i]     = 7'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            check_eq("rst_busy", busy_w[i], 1'b0);
            check_eq("rst_done", done_w[i], 1'b0);
            check_eq("rst_found", found_w[i], 1'b0);
            check_eq("rst_witness", witness_w[i], 7'd0);
            check_eq("rst_state", state_w[i], 2'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases with hand-derived results.
        run_search(0, 7'h00, 1'b1, 1'b0, f, w, lat);
        check_eq("d1_found", f, 1'b1);
        check_eq("d1_witness", w, 7'h20);
`ifdef FWS_SOL_COUNT_EN
        check_eq("d1_lat", lat, 4);
        check_eq("d1_sol", sol_w[0], 8'd2);
`else
        check_eq("d1_lat", lat, 2);
`endif
        run_search(0, 7'h05, 1'b0, 1'b0, f, w, lat);
        check_eq("d2_found", f, 1'b0);
        check_eq("d2_witness", w, 7'h00);
        check_eq("d2_lat", lat, 4);
        run_search(0, 7'h05, 1'b1, 1'b0, f, w, lat);
        check_eq("d3_found", f, 1'b1);
        check_eq("d3_witness", w, 7'h05);
`ifdef FWS_SOL_COUNT_EN
        check_eq("d3_sol", sol_w[0], 8'd4);
`else
        check_eq("d3_lat", lat, 1);
`endif
        // Masked bits of x_in must be ignored.
        run_search(0, 7'h62, 1'b1, 1'b0, f, w, lat);
        check_eq("d4_found", f, 1'b1);
        check_eq("d4_witness", w, 7'h02);

        // Reset one cycle into the next search.
        @(negedge clk);
        start_v[0] = 1'b1;
        x_v[0]     = 7'h00;
        tgt_v[0]   = 1'b1;
        @(posedge clk);
        #1;
        start_v[0] = 1'b0;
        check_eq("pre_rst_busy", busy_w[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_busy", busy_w[0], 1'b0);
        check_eq("mid_rst_done", done_w[0], 1'b0);
        check_eq("mid_rst_found", found_w[0], 1'b0);
        check_eq("mid_rst_witness", witness_w[0], 7'd0);
        check_eq("mid_rst_state", state_w[0], 2'd0);
`ifdef FWS_SOL_COUNT_EN
        check_eq("mid_rst_sol", sol_w[0], 8'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Random searches on the default mask.
        for (int t = 0; t < 24; t++) begin
            run_search(0, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), f, w, lat);
        end
        // Fully existential instance: x_in is irrelevant, target random.
        for (int t = 0; t < 8; t++) begin
            run_search(1, 7'($urandom_range(0, 127)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), f, w, lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
